// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - size encodings, FSM states and lane helpers for the RAM request adapter
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    function automatic logic access_err(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: access_err = 1'b0;
            SZ_HALF: access_err = offset[0];
            SZ_WORD: access_err = (offset != 2'b00);
            default: access_err = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << offset;
            SZ_HALF: lane_mask = 4'b0011 << offset;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ram_rdata_align.sv
// rtl/ram_rdata_align.sv - selects the addressed lane of a RAM word and zero/sign-extends it
module ram_rdata_align
    import mem_pkg::*;
(
    input  logic [31:0] ram_dout,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] rdata
);

    logic [31:0] lane;

    always_comb begin
        lane  = ram_dout >> {offset, 3'b000};
        rdata = lane;
        case (size)
            SZ_BYTE: rdata = {{24{~load_unsigned & lane[7]}}, lane[7:0]};
            SZ_HALF: rdata = {{16{~load_unsigned & lane[15]}}, lane[15:0]};
            default: rdata = lane;
        endcase
    end

endmodule

// File: rtl/ram_req_adapter.sv
// rtl/ram_req_adapter.sv - turns byte-addressed load/store requests into byte-lane RAM accesses
module ram_req_adapter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_din,
    input  logic [31:0]           ram_dout
);

    state_e                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            offset_q;
    logic [1:0]            size_q;
    logic                  unsigned_q;
    logic                  we_q;
    logic                  err_q;
    logic                  accept;
    logic                  req_err;
    logic [31:0]           aligned;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    assign req_ready = !rst && ((state == ST_IDLE) || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign req_err   = access_err(req_size, req_addr[1:0]);
    assign rsp_valid = (state == ST_RESP);

    // Holding the last address keeps ram_dout steady while a response is stalled.
    assign ram_addr = accept ? req_addr[ADDR_WIDTH+1:2] : addr_q;
    assign ram_we   = (accept && req_we && !req_err) ? lane_mask(req_size, req_addr[1:0]) : 4'b0000;

    always_comb begin
        case (req_size)
            SZ_BYTE: ram_din = {4{req_wdata[7:0]}};
            SZ_HALF: ram_din = {2{req_wdata[15:0]}};
            default: ram_din = req_wdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            offset_q   <= 2'b00;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (accept) state <= ST_RESP;
                ST_RESP: if (rsp_ready && !req_valid) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            if (accept) begin
                addr_q     <= req_addr[ADDR_WIDTH+1:2];
                offset_q   <= req_addr[1:0];
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                we_q       <= req_we;
                err_q      <= req_err;
            end
        end
    end

    ram_rdata_align u_align (
        .ram_dout      (ram_dout),
        .offset        (offset_q),
        .size          (size_q),
        .load_unsigned (unsigned_q),
        .rdata         (aligned)
    );

    assign rsp_rdata = (we_q || err_q) ? 32'h0 : aligned;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_ram_req_adapter.sv
// tb/tb_ram_req_adapter.sv - directed vector bench for ram_req_adapter with a synchronous RAM model
module tb_ram_req_adapter;

    localparam int AW = 12;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout;

    logic [31:0] mem [0:(1<<AW)-1];

    int checks;
    int errors;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [3:0]  exp_we;
        logic [31:0] exp_din;
        logic [11:0] exp_waddr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];
    vec_t bp   [4];

    ram_req_adapter #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
        ram_dout <= mem[ram_addr];
    end

    function automatic vec_t mk(input logic [31:0] addr, input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] wdata, input logic [3:0] exp_we,
                                input logic [31:0] exp_din, input logic [11:0] exp_waddr,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.addr = addr; v.we = we; v.size = size; v.uns = uns; v.wdata = wdata;
        v.exp_we = exp_we; v.exp_din = exp_din; v.exp_waddr = exp_waddr;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req_valid    = 1'b1;
        req_addr     = v.addr;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_wdata    = v.wdata;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        req_addr = 32'h0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'h0;

        //            addr          we    sz    uns   wdata         we_exp   din_exp       waddr   rdata         err
        vecs[0]  = mk(32'h0000_0008, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 4'hF,    32'hDEADBEEF, 12'd2, 32'h0,        1'b0);
        vecs[1]  = mk(32'h0000_0008, 1'b0, 2'd2, 1'b0, 32'h0,        4'h0,    32'h0,        12'd2, 32'hDEADBEEF, 1'b0);
        vecs[2]  = mk(32'h0000_0008, 1'b1, 2'd2, 1'b0, 32'h80FF1234, 4'hF,    32'h80FF1234, 12'd2, 32'h0,        1'b0);
        vecs[3]  = mk(32'h0000_000B, 1'b0, 2'd0, 1'b0, 32'h0,        4'h0,    32'h0,        12'd2, 32'hFFFFFF80, 1'b0);
        vecs[4]  = mk(32'h0000_000B, 1'b0, 2'd0, 1'b1, 32'h0,        4'h0,    32'h0,        12'd2, 32'h00000080, 1'b0);
        vecs[5]  = mk(32'h0000_0009, 1'b0, 2'd0, 1'b0, 32'h0,        4'h0,    32'h0,        12'd2, 32'h00000012, 1'b0);
        vecs[6]  = mk(32'h0000_000A, 1'b0, 2'd1, 1'b0, 32'h0,        4'h0,    32'h0,        12'd2, 32'hFFFF80FF, 1'b0);
        vecs[7]  = mk(32'h0000_000A, 1'b0, 2'd1, 1'b1, 32'h0,        4'h0,    32'h0,        12'd2, 32'h000080FF, 1'b0);
        vecs[8]  = mk(32'h0000_0004, 1'b1, 2'd2, 1'b0, 32'h11223344, 4'hF,    32'h11223344, 12'd1, 32'h0,        1'b0);
        vecs[9]  = mk(32'h0000_0006, 1'b1, 2'd1, 1'b0, 32'h0000ABCD, 4'b1100, 32'hABCDABCD, 12'd1, 32'h0,        1'b0);
        vecs[10] = mk(32'h0000_0004, 1'b0, 2'd2, 1'b0, 32'h0,        4'h0,    32'h0,        12'd1, 32'hABCD3344, 1'b0);
        vecs[11] = mk(32'h0000_0005, 1'b1, 2'd0, 1'b0, 32'h000000EE, 4'b0010, 32'hEEEEEEEE, 12'd1, 32'h0,        1'b0);
        vecs[12] = mk(32'h0000_0004, 1'b0, 2'd2, 1'b0, 32'h0,        4'h0,    32'h0,        12'd1, 32'hABCDEE44, 1'b0);
        vecs[13] = mk(32'h0000_0002, 1'b0, 2'd2, 1'b0, 32'h0,        4'h0,    32'h0,        12'd0, 32'h0,        1'b1);
        vecs[14] = mk(32'h0000_0004, 1'b1, 2'd3, 1'b0, 32'hFFFFFFFF, 4'h0,    32'h0,        12'd1, 32'h0,        1'b1);
        vecs[15] = mk(32'h0000_0005, 1'b1, 2'd1, 1'b0, 32'h00001234, 4'h0,    32'h0,        12'd1, 32'h0,        1'b1);
        vecs[16] = mk(32'h0000_0004, 1'b0, 2'd2, 1'b0, 32'h0,        4'h0,    32'h0,        12'd1, 32'hABCDEE44, 1'b0);
        vecs[17] = mk(32'h0000_4004, 1'b0, 2'd2, 1'b0, 32'h0,        4'h0,    32'h0,        12'd1, 32'hABCDEE44, 1'b0);
        vecs[18] = mk(32'h0000_0004, 1'b0, 2'd1, 1'b0, 32'h0,        4'h0,    32'h0,        12'd1, 32'hFFFFEE44, 1'b0);

        bp[0] = mk(32'h8, 1'b0, 2'd2, 1'b0, 32'h0, 4'h0, 32'h0, 12'd2, 32'h80FF1234, 1'b0);
        bp[1] = mk(32'h4, 1'b0, 2'd2, 1'b0, 32'h0, 4'h0, 32'h0, 12'd1, 32'hABCDEE44, 1'b0);
        bp[2] = mk(32'h6, 1'b0, 2'd1, 1'b1, 32'h0, 4'h0, 32'h0, 12'd1, 32'h0000ABCD, 1'b0);
        bp[3] = mk(32'hB, 1'b0, 2'd0, 1'b1, 32'h0, 4'h0, 32'h0, 12'd2, 32'h00000080, 1'b0);

        // Reset state, with a store presented that must not reach the RAM
        drive(vecs[0]);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset req_ready", {31'h0, req_ready}, 32'h0);
        check("reset ram_we", {28'h0, ram_we}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            rsp_ready = 1'b1;
            #1;
            check($sformatf("v%0d req_ready", i), {31'h0, req_ready}, 32'h1);
            check($sformatf("v%0d ram_we", i), {28'h0, ram_we}, {28'h0, vecs[i].exp_we});
            check($sformatf("v%0d ram_addr", i), {20'h0, ram_addr}, {20'h0, vecs[i].exp_waddr});
            if (vecs[i].exp_we != 4'h0)
                check($sformatf("v%0d ram_din", i), ram_din, vecs[i].exp_din);
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            check($sformatf("v%0d rsp_valid", i), {31'h0, rsp_valid}, 32'h1);
            check($sformatf("v%0d rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d rsp_err", i), {31'h0, rsp_err}, {31'h0, vecs[i].exp_err});
        end

        // Back-pressure: stall three cycles, then drain four queued loads back to back
        @(negedge clk);
        drive(bp[0]);
        rsp_ready = 1'b0;
        @(negedge clk);
        drive(bp[1]);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d req_ready", c), {31'h0, req_ready}, 32'h0);
            check($sformatf("stall%0d rsp_valid", c), {31'h0, rsp_valid}, 32'h1);
            check($sformatf("stall%0d rsp_rdata", c), rsp_rdata, bp[0].exp_rdata);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) drive(bp[k+1]);
            else       req_valid = 1'b0;
            #1;
            check($sformatf("drain%0d rsp_valid", k), {31'h0, rsp_valid}, 32'h1);
            check($sformatf("drain%0d rsp_rdata", k), rsp_rdata, bp[k].exp_rdata);
            check($sformatf("drain%0d req_ready", k), {31'h0, req_ready}, 32'h1);
            @(negedge clk);
        end
        #1;
        check("drain idle rsp_valid", {31'h0, rsp_valid}, 32'h0);

        // Reset asserted while a response is stalled
        @(negedge clk);
        drive(bp[0]);
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("pre-reset rsp_valid", {31'h0, rsp_valid}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("async reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("async reset req_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(bp[1]);
        rsp_ready = 1'b1;
        #1;
        check("post-reset req_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("post-reset rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check("post-reset rsp_rdata", rsp_rdata, bp[1].exp_rdata);
        @(negedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_req_adapter.md
RAM_REQ_ADAPTER -- requirements
Module: ram_req_adapter

Interface
REQ-001 Parameter: ADDR_WIDTH, default 12, word-address width driven to the byte-write RAM.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  adapter accepts the request this cycle.
REQ-006 req_addr  input  32  byte address.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-009 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  consumer takes the response.
REQ-013 rsp_rdata  output  32  aligned and extended load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  misaligned access or reserved size.
REQ-015 ram_we  output  4  byte-lane write enables to the RAM.
REQ-016 ram_addr  output  ADDR_WIDTH  RAM word address.
REQ-017 ram_din  output  32  lane-replicated store data.
REQ-018 ram_dout  input  32  RAM read data, valid one clk after the address.

Function
REQ-019 Accept condition: accept = req_valid && req_ready.
REQ-020 FSM states and transitions:
- IDLE: req_ready=1, rsp_valid=0.
- RESP: rsp_valid=1, req_ready=rsp_ready.
- Transitions: IDLE->RESP on accept. RESP->IDLE on rsp_ready && !req_valid. RESP->RESP on rsp_ready && req_valid (back-to-back). RESP->RESP on !rsp_ready (hold).
REQ-021 Latency and throughput: a request accepted at edge T produces rsp_valid in cycle T+1, which gives a sustained throughput of one access per clk.
REQ-022 Word address: ram_addr = req_addr[ADDR_WIDTH+1:2] on an accept cycle, otherwise the registered address of the last accepted request, so that ram_dout stays stable while a response stalls.
REQ-023 Alignment: half with addr[0]=1, word with addr[1:0]!=0, or size=3 is an error; an error access gets rsp_err=1, rsp_rdata=0 and ram_we=0.
REQ-024 Write enables: ram_we is nonzero only on an aligned, accepted store, with the following values.
- Byte: 4'b0001<<addr[1:0].
- Half: 4'b0011<<addr[1:0].
- Word: 4'b1111.
REQ-025 Store data: ram_din = {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, and wdata for word.
REQ-026 Load data: lane = ram_dout >> (8*offset), masked to size, then extended according to the registered unsigned flag; offset, size, unsigned, we and err are registered at accept.
REQ-027 Store response: a store responds with rsp_valid, rsp_rdata=0 and rsp_err=0 (or 1 if misaligned).
REQ-028 Response hold: while rsp_valid && !rsp_ready, rsp_rdata and rsp_err shall hold stable.
REQ-029 Address range: address bits above ADDR_WIDTH+1 are ignored, so accesses wrap modulo the RAM size.

Reset
REQ-030 While rst=1: state=IDLE, rsp_valid=0, req_ready=0, ram_we=0, and all registered fields=0.
REQ-031 An outstanding response is discarded when rst asserts mid-operation, and the first accept is possible in the first cycle after rst deasserts.

Structure
REQ-032 Shared package mem_pkg holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enumeration.
REQ-033 One sub-module, ram_rdata_align, performs the combinational lane select and extension (inputs ram_dout, offset, size, unsigned).

Verification
REQ-034 Word store addr 0x8, wdata 0xDEADBEEF, then word load 0x8 -> ram_we=4'hF at word address 2, and the load returns rsp_rdata=0xDEADBEEF one cycle after accept.
REQ-035 Byte load addr 0xB signed over RAM word 0x80FF1234 -> rsp_rdata=0xFFFFFF80; the same access unsigned -> 0x00000080.
REQ-036 Half store addr 0x6, wdata 0x0000ABCD -> ram_we=4'b1100, ram_din=0xABCDABCD; a following word load returns 0xABCDxxxx with the low half unchanged.
REQ-037 Misaligned word load at addr 0x2 -> rsp_err=1, rsp_rdata=0 and no RAM write; a size=3 store -> ram_we=0 and rsp_err=1.
REQ-038 Back-pressure: hold rsp_ready=0 for 3 cycles with req_valid high -> req_ready=0, response stable; then rsp_ready=1 for 4 cycles with 4 queued loads -> one response per cycle, in order.
REQ-039 Assert rst while in RESP -> rsp_valid=0 immediately (async); after release the first request is accepted in cycle 1 with correct data.
